// File: rtl/dmux4way16_stream.sv
// dmux4way16_stream: registered 4-way demultiplexer with valid/ready handshakes.
// One input word is steered by sel into one of four one-entry channel registers.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in         in   WIDTH  input word
//   sel        in   2      destination channel: 0=a 1=b 2=c 3=d
//   in_valid   in   1      producer presents a word
//   in_ready   out  1      selected channel can take the word this cycle
//   a,b,c,d    out  WIDTH  channel data
//   out_valid  out  4      per-channel holding register full ([0]=a .. [3]=d)
//   out_ready  in   4      per-channel consumer takes its word this cycle
//
// Optional feature macro: DMUX4WAY16_ZERO_IDLE_EN
//   defined   : a channel's data output reads 0 while its out_valid is 0
//   undefined : a channel's data output holds its last word after draining

module dmux4way16_stream #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
);

   logic [WIDTH-1:0] data_q [4];
   logic [3:0]       valid_q;
   logic             in_xfer;

   // A full channel can still accept when its consumer drains it this
   // same edge; that keeps one word per cycle on a streaming channel.
   assign in_ready = !valid_q[sel] | out_ready[sel];
   assign in_xfer  = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (in_xfer && (sel == 2'(i))) begin
               data_q[i]  <= in;
               valid_q[i] <= 1'b1;
            end else if (valid_q[i] && out_ready[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = valid_q;

`ifdef DMUX4WAY16_ZERO_IDLE_EN
   // Gate on the output side so the register itself never needs clearing.
   assign a = valid_q[0] ? data_q[0] : '0;
   assign b = valid_q[1] ? data_q[1] : '0;
   assign c = valid_q[2] ? data_q[2] : '0;
   assign d = valid_q[3] ? data_q[3] : '0;
`else
   assign a = data_q[0];
   assign b = data_q[1];
   assign c = data_q[2];
   assign d = data_q[3];
`endif

endmodule
